// File: rtl/prog_loader.sv
// Program loader: streams host words into CPU program RAM, then runs the CPU for a bounded time.
// Optional checksum word after the program is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int DATA_W     = 11,
    parameter int ADDR_W     = 3,
    parameter int RUN_CYCLES = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    input  logic              host_last,
    output logic              host_ready,
    output logic              cpu_reset,
    output logic              RAM_Write_Enable,
    output logic [ADDR_W-1:0] RAM_Write_Address,
    output logic [DATA_W-1:0] RAM_Write_Data,
    output logic              PC_Enable,
    output logic [ADDR_W:0]   loaded_count,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int RC_W  = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [RC_W-1:0]   RUN_LAST   = RC_W'((RUN_CYCLES > 0) ? RUN_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RUN   = 3'd4,
        ST_HALT  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    state_t              state_r;
    state_t              state_c_s;
    state_t              state_nxt_s;
    logic [ADDR_W-1:0]   ptr_r;
    logic [ADDR_W:0]     count_r;
    logic                we_r;
    logic [ADDR_W-1:0]   waddr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [RC_W-1:0]     run_cnt_r;
    logic                cpu_reset_r;
    logic                host_ready_r;
    logic                pc_en_r;
    logic                busy_r;
    logic                done_r;
    logic                xfer_s;
    logic                end_s;
    logic                wr_c_s;
    logic                wr_s;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]   csum_r;
    logic                csum_phase_r;
    logic                err_r;

    function automatic logic [DATA_W-1:0] xor_fold(input logic [DATA_W-1:0] acc,
                                                    input logic [DATA_W-1:0] word);
        return acc ^ word;
    endfunction
`endif

    assign xfer_s = host_ready_r && host_valid;
    assign end_s  = xfer_s && (host_last || (ptr_r == LAST_ADDR));

    // Next-state and RAM write decision; abort overrides everything but reset.
    always_comb begin
        state_c_s   = state_r;
        wr_c_s      = 1'b0;
        state_nxt_s = state_r;
        wr_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) state_c_s = ST_CLR;
                else       state_c_s = ST_IDLE;
            end
            ST_CLR: state_c_s = ST_LOAD;
            ST_LOAD: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                if (csum_phase_r) begin
                    // The checksum word itself is never written to RAM.
                    wr_c_s = 1'b0;
                    if (xfer_s) state_c_s = (host_data == csum_r) ? ST_DRAIN : ST_ERR;
                    else        state_c_s = ST_LOAD;
                end else begin
                    wr_c_s    = xfer_s;
                    state_c_s = ST_LOAD;
                end
`else
                wr_c_s = xfer_s;
                if (end_s) state_c_s = ST_DRAIN;
                else       state_c_s = ST_LOAD;
`endif
            end
            ST_DRAIN: state_c_s = ST_RUN;
            ST_RUN: begin
                if ((RUN_CYCLES != 0) && (run_cnt_r == RUN_LAST)) state_c_s = ST_HALT;
                else                                              state_c_s = ST_RUN;
            end
            ST_HALT, ST_ERR: begin
                if (start) state_c_s = ST_CLR;
                else       state_c_s = state_r;
            end
            default: state_c_s = ST_IDLE;
        endcase
        if (abort) begin
            state_nxt_s = ST_IDLE;
            wr_s        = 1'b0;
        end else begin
            state_nxt_s = state_c_s;
            wr_s        = wr_c_s;
        end
    end

    // State, datapath and registered outputs (outputs follow the next state).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            ptr_r        <= '0;
            count_r      <= '0;
            we_r         <= 1'b0;
            waddr_r      <= '0;
            wdata_r      <= '0;
            run_cnt_r    <= '0;
            cpu_reset_r  <= 1'b1;
            host_ready_r <= 1'b0;
            pc_en_r      <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            we_r    <= wr_s;
            if (state_r == ST_CLR) begin
                ptr_r   <= '0;
                count_r <= '0;
            end else if (wr_s) begin
                waddr_r <= ptr_r;
                wdata_r <= host_data;
                // Pointer holds at the top address; count saturates at full depth.
                if (ptr_r != LAST_ADDR)    ptr_r   <= ptr_r + ADDR_W'(1);
                if (count_r != FULL_COUNT) count_r <= count_r + (ADDR_W + 1)'(1);
            end
            if (state_r == ST_RUN) run_cnt_r <= run_cnt_r + RC_W'(1);
            else                   run_cnt_r <= '0;
            cpu_reset_r  <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_CLR);
            host_ready_r <= (state_nxt_s == ST_LOAD);
            pc_en_r      <= (state_nxt_s == ST_RUN);
            busy_r       <= (state_nxt_s == ST_CLR) || (state_nxt_s == ST_LOAD) ||
                            (state_nxt_s == ST_DRAIN) || (state_nxt_s == ST_RUN);
            done_r       <= (state_nxt_s == ST_HALT);
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // Running XOR of written words and the flag that the next word is the checksum.
    always_ff @(posedge clk) begin
        if (reset) begin
            csum_r       <= '0;
            csum_phase_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            if (state_r == ST_CLR) begin
                csum_r       <= '0;
                csum_phase_r <= 1'b0;
            end else if (wr_s) begin
                csum_r <= xor_fold(csum_r, host_data);
                if (end_s) csum_phase_r <= 1'b1;
            end
            err_r <= (state_nxt_s == ST_ERR);
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign host_ready        = host_ready_r;
    assign cpu_reset         = cpu_reset_r;
    assign RAM_Write_Enable  = we_r;
    assign RAM_Write_Address = waddr_r;
    assign RAM_Write_Data    = wdata_r;
    assign PC_Enable         = pc_en_r;
    assign loaded_count      = count_r;
    assign busy              = busy_r;
    assign done              = done_r;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (default build, or checksum build when
// PROG_LOADER_CHECKSUM_EN is defined).
module tb_prog_loader;
    localparam int DATA_W = 11;
    localparam int ADDR_W = 3;
    localparam int RUN_CYCLES = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              host_valid = 1'b0;
    logic [DATA_W-1:0] host_data = '0;
    logic              host_last = 1'b0;
    logic              host_ready, cpu_reset, RAM_Write_Enable, PC_Enable, busy, done, err;
    logic [ADDR_W-1:0] RAM_Write_Address;
    logic [DATA_W-1:0] RAM_Write_Data;
    logic [ADDR_W:0]   loaded_count;

    int tests = 0;
    int fails = 0;
    int wr_n = 0;
    int wr_base = 0;
    int pcn = 0;
    int k = 0;

    logic [DATA_W-1:0] hp [6] = '{11'h7B0, 11'h590, 11'h408, 11'h190, 11'h302, 11'h5E0};
    logic [DATA_W-1:0] gw [3] = '{11'h011, 11'h022, 11'h033};
    logic              gv [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    prog_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RUN_CYCLES(RUN_CYCLES)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .host_valid(host_valid), .host_data(host_data), .host_last(host_last),
        .host_ready(host_ready), .cpu_reset(cpu_reset),
        .RAM_Write_Enable(RAM_Write_Enable), .RAM_Write_Address(RAM_Write_Address),
        .RAM_Write_Data(RAM_Write_Data), .PC_Enable(PC_Enable),
        .loaded_count(loaded_count), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Count every cycle that carried a write strobe.
    always @(posedge clk) begin
        if (RAM_Write_Enable === 1'b1) wr_n <= wr_n + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic go_load();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("clr_busy", busy, 1);
        chk("clr_cpu_reset", cpu_reset, 1);
        chk("clr_ready", host_ready, 0);
        @(negedge clk);
        chk("load_ready", host_ready, 1);
        chk("load_cpu_reset", cpu_reset, 0);
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic l);
        host_valid = 1'b1;
        host_data  = d;
        host_last  = l;
        @(negedge clk);
        host_valid = 1'b0;
        host_last  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", done, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_ready", host_ready, 0);
        chk("rst_we", RAM_Write_Enable, 0);
        chk("rst_pc", PC_Enable, 0);
        chk("rst_count", loaded_count, 0);
        chk("rst_addr", RAM_Write_Address, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_cpu_reset", cpu_reset, 1);

`ifndef PROG_LOADER_CHECKSUM_EN
        // Happy path: six back-to-back words.
        wr_base = wr_n;
        go_load();
        for (int i = 0; i < 6; i++) begin
            send(hp[i], (i == 5));
            chk("hp_we", RAM_Write_Enable, 1);
            chk("hp_addr", RAM_Write_Address, i);
            chk("hp_data", RAM_Write_Data, hp[i]);
        end
        chk("hp_drain_ready", host_ready, 0);
        chk("hp_drain_pc", PC_Enable, 0);
        @(negedge clk);
        chk("hp_pc_rise", PC_Enable, 1);
        chk("hp_we_after", RAM_Write_Enable, 0);
        pcn = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (PC_Enable !== 1'b1) break;
            pcn++;
        end
        chk("hp_pc_cycles", pcn, 8);
        chk("hp_done", done, 1);
        chk("hp_count", loaded_count, 6);
        chk("hp_cpu_reset", cpu_reset, 0);
        chk("hp_busy", busy, 0);
        chk("hp_err", err, 0);
        chk("hp_strobes", wr_n - wr_base, 6);

        // Full depth: eight words with no last marker.
        wr_base = wr_n;
        go_load();
        for (int i = 0; i < 8; i++) begin
            send(11'(11'h100 + i), 1'b0);
            chk("fd_addr", RAM_Write_Address, i);
            chk("fd_data", RAM_Write_Data, 11'h100 + i);
        end
        chk("fd_drain_ready", host_ready, 0);
        chk("fd_count", loaded_count, 8);
        host_valid = 1'b1;
        host_data  = 11'h7FF;
        @(negedge clk);
        host_valid = 1'b0;
        chk("fd_ninth_we", RAM_Write_Enable, 0);
        chk("fd_ninth_ready", host_ready, 0);
        wait_done(20);
        chk("fd_strobes", wr_n - wr_base, 8);

        // Gapped stream.
        wr_base = wr_n;
        go_load();
        k = 0;
        for (int c = 0; c < 6; c++) begin
            if (gv[c]) begin
                send(gw[k], (k == 2));
                chk("gap_we", RAM_Write_Enable, 1);
                chk("gap_addr", RAM_Write_Address, k);
                chk("gap_data", RAM_Write_Data, gw[k]);
                k++;
            end else begin
                host_data = 11'h7FF;
                @(negedge clk);
                chk("gap_idle_we", RAM_Write_Enable, 0);
            end
        end
        wait_done(20);
        chk("gap_strobes", wr_n - wr_base, 3);

        // Abort after three transfers, then restart.
        wr_base = wr_n;
        go_load();
        send(11'h001, 1'b0);
        send(11'h002, 1'b0);
        send(11'h003, 1'b0);
        chk("ab_third_addr", RAM_Write_Address, 2);
        chk("ab_third_we", RAM_Write_Enable, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_ready", host_ready, 0);
        chk("ab_cpu_reset", cpu_reset, 1);
        chk("ab_we", RAM_Write_Enable, 0);
        chk("ab_busy", busy, 0);
        @(negedge clk);
        chk("ab_strobes", wr_n - wr_base, 3);
        go_load();
        send(11'h055, 1'b1);
        chk("rs_addr", RAM_Write_Address, 0);
        chk("rs_data", RAM_Write_Data, 11'h055);
        chk("rs_count", loaded_count, 1);

        // Reset on the fourth PC_Enable cycle.
        repeat (4) @(negedge clk);
        chk("rr_pc4", PC_Enable, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rr_pc", PC_Enable, 0);
        chk("rr_cpu_reset", cpu_reset, 1);
        chk("rr_count", loaded_count, 0);
        chk("rr_busy", busy, 0);
`else
        // Checksum match.
        wr_base = wr_n;
        go_load();
        send(11'h003, 1'b0);
        send(11'h7B0, 1'b1);
        chk("cs_wait_ready", host_ready, 1);
        chk("cs_addr", RAM_Write_Address, 1);
        send(11'h7B3, 1'b0);
        chk("cs_no_write", RAM_Write_Enable, 0);
        chk("cs_drain_ready", host_ready, 0);
        chk("cs_err", err, 0);
        @(negedge clk);
        chk("cs_pc", PC_Enable, 1);
        chk("cs_count", loaded_count, 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("cs_strobes", wr_n - wr_base, 2);

        // Checksum mismatch.
        wr_base = wr_n;
        go_load();
        send(11'h003, 1'b0);
        send(11'h7B0, 1'b1);
        send(11'h000, 1'b0);
        chk("cm_err", err, 1);
        chk("cm_cpu_reset", cpu_reset, 0);
        pcn = 0;
        for (int c = 0; c < 10; c++) begin
            if (PC_Enable === 1'b1) pcn++;
            @(negedge clk);
        end
        chk("cm_pc_never", pcn, 0);
        chk("cm_err_held", err, 1);
        chk("cm_strobes", wr_n - wr_base, 2);
        go_load();
        chk("cm_restart_err", err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
